// File: rtl/srlat_pkg.sv
// Shared encodings and helpers for the srlat storage bank.
// Polarity and priority encodings are single bits so they compare directly against pins.
package srlat_pkg;

    localparam bit POL_HIGH = 1'b1;
    localparam bit POL_LOW  = 1'b0;

    localparam bit PRIO_CLR = 1'b1;
    localparam bit PRIO_SET = 1'b0;

    // Width of an age counter that must hold values 0..stale_max inclusive.
    function automatic int age_w(input int stale_max);
        return (stale_max < 1) ? 1 : $clog2(stale_max + 1);
    endfunction

endpackage

// File: rtl/srlat_chan.sv
// One storage channel: WIDTH-bit register with clear/set/load priority,
// a saturating age counter, a stale flag and a set/clr conflict pulse.
module srlat_chan
    import srlat_pkg::*;
#(
    parameter int              WIDTH        = 8,
    parameter bit              EN_POL       = POL_HIGH,
    parameter bit              SET_POL      = POL_HIGH,
    parameter bit              CLR_POL      = POL_HIGH,
    parameter bit              CLR_OVER_SET = PRIO_CLR,
    parameter logic [WIDTH-1:0] INIT        = '0,
    parameter int              STALE_MAX    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frz_i,
    input  logic             en_i,
    input  logic             set_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             stale_o,
    output logic             conflict_o
);

    localparam int               AGE_W   = age_w(STALE_MAX);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STALE_MAX);

    logic             en_act;
    logic             set_act;
    logic             clr_act;
    logic             load_act;
    logic             any_load;

    logic [WIDTH-1:0] q_q,        q_d;
    logic [AGE_W-1:0] age_q,      age_d;
    logic             stale_q,    stale_d;
    logic             conflict_q, conflict_d;

    assign en_act   = (en_i  == EN_POL);
    assign set_act  = (set_i == SET_POL);
    assign clr_act  = (clr_i == CLR_POL);
    assign load_act = en_act & ~frz_i;
    // Any winning action counts as a load, even if it rewrites the same value.
    assign any_load = clr_act | set_act | load_act;

    always_comb begin
        q_d = q_q;
        if (CLR_OVER_SET == PRIO_CLR) begin
            if (clr_act) begin
                q_d = '0;
            end else if (set_act) begin
                q_d = '1;
            end else if (load_act) begin
                q_d = d_i;
            end
        end else begin
            if (set_act) begin
                q_d = '1;
            end else if (clr_act) begin
                q_d = '0;
            end else if (load_act) begin
                q_d = d_i;
            end
        end
    end

    always_comb begin
        age_d = age_q;
        if (any_load) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    // Stale is derived from the next age so it is registered alongside it.
    assign stale_d    = (age_d == AGE_MAX);
    assign conflict_d = set_act & clr_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= INIT;
            age_q      <= '0;
            stale_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            age_q      <= age_d;
            stale_q    <= stale_d;
            conflict_q <= conflict_d;
        end
    end

    assign q_o        = q_q;
    assign stale_o    = stale_q;
    assign conflict_o = conflict_q;

endmodule

// File: rtl/srlat_bank.sv
// N_CH independent clocked storage channels sharing reset and freeze,
// with per-channel age/stale tracking and set/clr conflict reporting.
module srlat_bank
    import srlat_pkg::*;
#(
    parameter int               N_CH         = 4,
    parameter int               WIDTH        = 8,
    parameter bit               EN_POL       = POL_HIGH,
    parameter bit               SET_POL      = POL_HIGH,
    parameter bit               CLR_POL      = POL_HIGH,
    parameter bit               CLR_OVER_SET = PRIO_CLR,
    parameter logic [WIDTH-1:0] INIT         = '0,
    parameter int               STALE_MAX    = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frz,
    input  logic [N_CH-1:0]         en,
    input  logic [N_CH-1:0]         set,
    input  logic [N_CH-1:0]         clr,
    input  logic [N_CH*WIDTH-1:0]   d,
    output logic [N_CH*WIDTH-1:0]   q,
    output logic [N_CH-1:0]         stale,
    output logic [N_CH-1:0]         conflict
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        srlat_chan #(
            .WIDTH        (WIDTH),
            .EN_POL       (EN_POL),
            .SET_POL      (SET_POL),
            .CLR_POL      (CLR_POL),
            .CLR_OVER_SET (CLR_OVER_SET),
            .INIT         (INIT),
            .STALE_MAX    (STALE_MAX)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .frz_i      (frz),
            .en_i       (en[gi]),
            .set_i      (set[gi]),
            .clr_i      (clr[gi]),
            .d_i        (d[gi*WIDTH +: WIDTH]),
            .q_o        (q[gi*WIDTH +: WIDTH]),
            .stale_o    (stale[gi]),
            .conflict_o (conflict[gi])
        );
    end

endmodule

// File: tb/tb_srlat_bank.sv
// Bench for srlat_bank: three instances (clear-priority, set-priority, active-low controls)
// driven by one logical stimulus stream and checked against a per-cycle behavioural model.
module tb_srlat_bank;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SM = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           frz;
    logic [N-1:0]   l_en, l_set, l_clr;
    logic [N*W-1:0] d;

    logic [N-1:0]   en_c, set_c, clr_c;
    assign en_c  = ~l_en;
    assign set_c = ~l_set;
    assign clr_c = ~l_clr;

    logic [N*W-1:0] q_a, q_b, q_c;
    logic [N-1:0]   stale_a, stale_b, stale_c;
    logic [N-1:0]   conf_a, conf_b, conf_c;

    srlat_bank #(.N_CH(N), .WIDTH(W), .EN_POL(1'b1), .SET_POL(1'b1), .CLR_POL(1'b1),
                 .CLR_OVER_SET(1'b1), .INIT(8'hA5), .STALE_MAX(SM)) dut_a (
        .clk(clk), .rst(rst), .frz(frz), .en(l_en), .set(l_set), .clr(l_clr), .d(d),
        .q(q_a), .stale(stale_a), .conflict(conf_a));

    srlat_bank #(.N_CH(N), .WIDTH(W), .EN_POL(1'b1), .SET_POL(1'b1), .CLR_POL(1'b1),
                 .CLR_OVER_SET(1'b0), .INIT(8'hA5), .STALE_MAX(SM)) dut_b (
        .clk(clk), .rst(rst), .frz(frz), .en(l_en), .set(l_set), .clr(l_clr), .d(d),
        .q(q_b), .stale(stale_b), .conflict(conf_b));

    srlat_bank #(.N_CH(N), .WIDTH(W), .EN_POL(1'b0), .SET_POL(1'b0), .CLR_POL(1'b0),
                 .CLR_OVER_SET(1'b1), .INIT(8'hC3), .STALE_MAX(SM)) dut_c (
        .clk(clk), .rst(rst), .frz(frz), .en(en_c), .set(set_c), .clr(clr_c), .d(d),
        .q(q_c), .stale(stale_c), .conflict(conf_c));

    int checks = 0;
    int errors = 0;

    // Behavioural model: one value, age and conflict flag per instance and channel.
    logic [W-1:0] m_q    [3][N];
    int           m_age  [3][N];
    logic         m_conf [3][N];

    function automatic logic [W-1:0] init_of(input int k);
        return (k == 2) ? 8'hC3 : 8'hA5;
    endfunction

    function automatic bit clr_wins(input int k);
        return (k != 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < N; c++) begin
                if (rst) begin
                    m_q[k][c]    = init_of(k);
                    m_age[k][c]  = 0;
                    m_conf[k][c] = 1'b0;
                end else begin
                    bit s, cl, e;
                    s  = l_set[c];
                    cl = l_clr[c];
                    e  = l_en[c] && !frz;
                    m_conf[k][c] = s && cl;
                    if (s && cl)  m_q[k][c] = clr_wins(k) ? 8'h00 : 8'hFF;
                    else if (cl)  m_q[k][c] = 8'h00;
                    else if (s)   m_q[k][c] = 8'hFF;
                    else if (e)   m_q[k][c] = d[c*W +: W];
                    if (s || cl || e)      m_age[k][c] = 0;
                    else if (m_age[k][c] < SM) m_age[k][c] = m_age[k][c] + 1;
                end
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            logic [N*W-1:0] eq, aq;
            logic [N-1:0]   es, ec, as, ac;
            for (int c = 0; c < N; c++) begin
                eq[c*W +: W] = m_q[k][c];
                es[c]        = (m_age[k][c] == SM);
                ec[c]        = m_conf[k][c];
            end
            case (k)
                0:       begin aq = q_a; as = stale_a; ac = conf_a; end
                1:       begin aq = q_b; as = stale_b; ac = conf_b; end
                default: begin aq = q_c; as = stale_c; ac = conf_c; end
            endcase
            chk($sformatf("model_q dut%0d", k),     aq, eq);
            chk($sformatf("model_stale dut%0d", k), 32'(as), 32'(es));
            chk($sformatf("model_conf dut%0d", k),  32'(ac), 32'(ec));
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model();
        $display("[%0t] %s rst=%b frz=%b en=%b set=%b clr=%b d=%h | qa=%h qb=%h qc=%h stale=%b conf=%b",
                 $time, tag, rst, frz, l_en, l_set, l_clr, d, q_a, q_b, q_c, stale_a, conf_a);
    endtask

    function automatic logic [W-1:0] byte_of(input logic [N*W-1:0] v, input int c);
        return v[c*W +: W];
    endfunction

    typedef struct {
        logic         rst;
        logic         frz;
        logic [N-1:0] en;
        logic [N-1:0] set;
        logic [N-1:0] clr;
        logic [31:0]  d;
        int           ch;
        logic [7:0]   ea;
        logic [7:0]   eb;
        logic [7:0]   ec;
        logic         econf;
    } vec_t;

    vec_t tbl[16];

    initial begin
        rst = 1'b1; frz = 1'b0; l_en = '0; l_set = '0; l_clr = '0; d = '0;

        tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 0, 8'hA5, 8'hA5, 8'hC3, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 2, 8'hA5, 8'hA5, 8'hC3, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 32'h0000_003C, 0, 8'h3C, 8'h3C, 8'h3C, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 32'h0000_00EE, 0, 8'h3C, 8'h3C, 8'h3C, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 4'h0, 4'h2, 4'h2, 32'h0000_0000, 1, 8'h00, 8'hFF, 8'h00, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 1, 8'h00, 8'hFF, 8'h00, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 32'h0000_005A, 0, 8'h5A, 8'h5A, 8'h5A, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 32'h0000_005A, 0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 32'hFFFF_FFFF, 0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 32'h0000_0000, 0, 8'hFF, 8'hFF, 8'hFF, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 32'h1234_5678, 3, 8'hA5, 8'hA5, 8'hC3, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 4'h4, 4'h0, 4'h0, 32'h0077_0000, 2, 8'hA5, 8'hA5, 8'hC3, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 32'h0077_0000, 2, 8'hA5, 8'hA5, 8'hC3, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 4'h4, 4'h4, 4'h0, 32'h0011_0000, 2, 8'hFF, 8'hFF, 8'hFF, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 4'h4, 4'h0, 4'h4, 32'h0011_0000, 2, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 4'h4, 4'h0, 4'h0, 32'h0099_0000, 2, 8'h99, 8'h99, 8'h99, 1'b0};

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; frz = tbl[i].frz;
            l_en = tbl[i].en; l_set = tbl[i].set; l_clr = tbl[i].clr; d = tbl[i].d;
            cycle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d q_a ch%0d", i, tbl[i].ch), 32'(byte_of(q_a, tbl[i].ch)), 32'(tbl[i].ea));
            chk($sformatf("vec%0d q_b ch%0d", i, tbl[i].ch), 32'(byte_of(q_b, tbl[i].ch)), 32'(tbl[i].eb));
            chk($sformatf("vec%0d q_c ch%0d", i, tbl[i].ch), 32'(byte_of(q_c, tbl[i].ch)), 32'(tbl[i].ec));
            chk($sformatf("vec%0d conf ch%0d", i, tbl[i].ch), 32'(conf_a[tbl[i].ch]), 32'(tbl[i].econf));
            if (tbl[i].rst) chk($sformatf("vec%0d stale reset", i), 32'(stale_a), 32'h0);
        end

        // Stale timing: load ch0, then hold it frozen with en asserted; stale rises 15 edges later.
        rst = 1'b0; frz = 1'b0; l_set = '0; l_clr = '0; l_en = 4'h1; d = 32'h0000_0012;
        cycle("stale_load");
        chk("stale_after_load", 32'(stale_a[0]), 32'h0);
        for (int k = 1; k <= 17; k++) begin
            frz = 1'b1; l_en = 4'hF; d = 32'hFFFF_FFFF;
            cycle($sformatf("stale_age%0d", k));
            chk($sformatf("stale_a ch0 age%0d", k), 32'(stale_a[0]), (k >= SM) ? 32'h1 : 32'h0);
            chk($sformatf("stale_c ch0 age%0d", k), 32'(stale_c[0]), (k >= SM) ? 32'h1 : 32'h0);
            chk($sformatf("frozen q ch0 age%0d", k), 32'(byte_of(q_a, 0)), 32'h12);
        end
        frz = 1'b0; l_en = 4'h1; d = 32'h0000_0034;
        cycle("stale_reload");
        chk("stale_cleared_by_load", 32'(stale_a[0]), 32'h0);
        chk("reload_q ch0", 32'(byte_of(q_a, 0)), 32'h34);

        // Randomised traffic with alternating busy and quiet phases so stale is reached too.
        for (int i = 0; i < 400; i++) begin
            bit quiet;
            quiet = ((i / 48) % 2) == 1;
            rst = ($urandom_range(0, 63) == 0);
            frz = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < N; c++) begin
                l_en[c]  = quiet ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
                l_set[c] = quiet ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 5) == 0);
                l_clr[c] = quiet ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 5) == 0);
            end
            d = $urandom;
            cycle($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
